// File: rtl/jk_bank_ctrl.sv
// jk_bank_ctrl: command sequencer for a bank of JK flops sharing clk1.
// Drives registered J/K pulse trains (set/clear/toggle/hold) under a
// valid/ready command handshake and returns the bank Q on a response
// handshake. Optional feature macro: JK_VERIFY_EN (read-back check on rsp_err).
//
//   state  | meaning
//   IDLE   | ready for a command, J=K=0
//   DRIVE  | one cycle with the op pattern on J/K; bank updates leaving it
//   SETTLE | one quiet cycle (J=K=0); repeat DRIVE or capture Q
//   RESP   | rsp_valid high, rsp_q/rsp_err held until rsp_ready
module jk_bank_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk1,
    input  logic             s_reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_mask,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    input  logic [WIDTH-1:0] jk_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_q,
    output logic             rsp_err,
    output logic             busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_SETTLE, ST_RESP} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [WIDTH-1:0] jk_j_q, jk_j_d;
    logic [WIDTH-1:0] jk_k_q, jk_k_d;
`ifdef JK_VERIFY_EN
    logic             first_q, first_d;
    logic             odd_q, odd_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             err_q, err_d;
`endif

    // J is asserted for set and toggle (op bit 0), K for clear and toggle (op bit 1).
    function automatic logic [WIDTH-1:0] pat_j(input logic [1:0] op, input logic [WIDTH-1:0] m);
        return op[0] ? m : '0;
    endfunction

    function automatic logic [WIDTH-1:0] pat_k(input logic [1:0] op, input logic [WIDTH-1:0] m);
        return op[1] ? m : '0;
    endfunction

    // State and datapath registers; reset drops any in-flight command.
    always_ff @(posedge clk1 or posedge s_reset) begin
        if (s_reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            mask_q     <= '0;
            rem_q      <= '0;
            rsp_data_q <= '0;
            jk_j_q     <= '0;
            jk_k_q     <= '0;
`ifdef JK_VERIFY_EN
            first_q    <= 1'b0;
            odd_q      <= 1'b0;
            exp_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mask_q     <= mask_d;
            rem_q      <= rem_d;
            rsp_data_q <= rsp_data_d;
            jk_j_q     <= jk_j_d;
            jk_k_q     <= jk_k_d;
`ifdef JK_VERIFY_EN
            first_q    <= first_d;
            odd_q      <= odd_d;
            exp_q      <= exp_d;
            err_q      <= err_d;
`endif
        end
    end

    // Next state; J/K are loaded only on the edge entering DRIVE so they are zero elsewhere.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        mask_d     = mask_q;
        rem_d      = rem_q;
        rsp_data_d = rsp_data_q;
        jk_j_d     = '0;
        jk_k_d     = '0;
`ifdef JK_VERIFY_EN
        first_d    = first_q;
        odd_d      = odd_q;
        exp_d      = exp_q;
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    mask_d  = cmd_mask;
                    rem_d   = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
                    jk_j_d  = pat_j(cmd_op, cmd_mask);
                    jk_k_d  = pat_k(cmd_op, cmd_mask);
                    state_d = ST_DRIVE;
`ifdef JK_VERIFY_EN
                    first_d = 1'b1;
                    odd_d   = (cmd_count == '0) ? 1'b1 : cmd_count[0];
`endif
                end
            end
            ST_DRIVE: begin
                state_d = ST_SETTLE;
`ifdef JK_VERIFY_EN
                // Q has not yet seen the first pulse here, so it is the starting snapshot.
                if (first_q) begin
                    first_d = 1'b0;
                    case (op_q)
                        2'b01:   exp_d = jk_q | mask_q;
                        2'b10:   exp_d = jk_q & ~mask_q;
                        2'b11:   exp_d = jk_q ^ (odd_q ? mask_q : '0);
                        default: exp_d = jk_q;
                    endcase
                end
`endif
            end
            ST_SETTLE: begin
                if (rem_q > CNT_W'(1)) begin
                    rem_d   = rem_q - CNT_W'(1);
                    jk_j_d  = pat_j(op_q, mask_q);
                    jk_k_d  = pat_k(op_q, mask_q);
                    state_d = ST_DRIVE;
                end else begin
                    rsp_data_d = jk_q;
                    state_d    = ST_RESP;
`ifdef JK_VERIFY_EN
                    err_d      = (jk_q != exp_q);
`endif
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
`ifdef JK_VERIFY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_q     = rsp_data_q;
    assign jk_j      = jk_j_q;
    assign jk_k      = jk_k_q;
`ifdef JK_VERIFY_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Bench for jk_bank_ctrl: behavioural JK bank on clk1 with a stuck-at-0 hook,
// expected responses queued at command issue and compared at the handshake.
module tb_jk_bank_ctrl;

    logic       clk1 = 1'b0;
    logic       s_reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_mask;
    logic [3:0] cmd_count;
    logic [7:0] jk_j, jk_k, jk_q;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_q;
    logic       rsp_err;
    logic       busy;

    logic       bank_rst;
    logic [7:0] bank_q;
    logic [7:0] stuck;
    logic [7:0] q_track;

    logic [7:0] exp_q_fifo[$];
    bit         exp_e_fifo[$];

    int n_cmp = 0;
    int n_bad = 0;

    jk_bank_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk1(clk1), .s_reset(s_reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_count(cmd_count),
        .jk_j(jk_j), .jk_k(jk_k), .jk_q(jk_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk1 = ~clk1;

    // Bank of JK flops; stuck bits read back as 0.
    always @(posedge clk1 or posedge bank_rst) begin
        if (bank_rst) bank_q <= 8'h00;
        else begin
            for (int i = 0; i < 8; i++) begin
                case ({jk_j[i], jk_k[i]})
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end
    assign jk_q = bank_q & ~stuck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] jk_model(input logic [1:0] op, input logic [7:0] mask,
                                            input int n, input logic [7:0] q);
        logic [7:0] r = q;
        for (int i = 0; i < n; i++) begin
            case (op)
                2'b01:   r = r | mask;
                2'b10:   r = r & ~mask;
                2'b11:   r = r ^ mask;
                default: r = r;
            endcase
        end
        return r;
    endfunction

    task automatic bank_reset();
        bank_rst = 1'b1;
        @(posedge clk1); #1;
        bank_rst = 1'b0;
        q_track  = 8'h00;
    endtask

    // Wait (bounded) for cmd_ready, present the command, queue its expected response.
    task automatic issue(input logic [1:0] op, input logic [7:0] mask, input logic [3:0] cnt,
                         input bit expect_rsp);
        int n;
        int waited = 0;
        logic [7:0] ideal, actual;
        while (cmd_ready !== 1'b1 && waited < 20) begin
            @(posedge clk1); #1;
            waited++;
        end
        if (cmd_ready !== 1'b1) check("ready_timeout", 32'(cmd_ready), 32'd1);
        n      = (cnt == 4'd0) ? 1 : int'(cnt);
        ideal  = jk_model(op, mask, n, q_track);
        actual = ideal & ~stuck;
        if (expect_rsp) begin
            exp_q_fifo.push_back(actual);
`ifdef JK_VERIFY_EN
            exp_e_fifo.push_back(ideal != actual);
`else
            exp_e_fifo.push_back(1'b0);
`endif
            q_track = actual;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_mask  = mask;
        cmd_count = cnt;
        @(posedge clk1); #1;
        cmd_valid = 1'b0;
        cmd_count = 4'($urandom);
    endtask

    // Called 1 time unit after the accept edge: checks the DRIVE/SETTLE train and rsp_valid timing.
    task automatic watch(input logic [1:0] op, input logic [7:0] mask, input logic [3:0] cnt);
        int n = (cnt == 4'd0) ? 1 : int'(cnt);
        logic [7:0] pj = op[0] ? mask : 8'h00;
        logic [7:0] pk = op[1] ? mask : 8'h00;
        for (int k = 0; k < 2 * n; k++) begin
            check("jk_j_train", 32'(jk_j), 32'((k % 2 == 0) ? pj : 8'h00));
            check("jk_k_train", 32'(jk_k), 32'((k % 2 == 0) ? pk : 8'h00));
            check("rsp_valid_early", 32'(rsp_valid), 32'd0);
            check("busy_train", 32'(busy), 32'd1);
            @(posedge clk1); #1;
        end
        check("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    endtask

    // Hold off rsp_ready for stall cycles, then take the response and compare with the queue.
    task automatic respond(input int stall);
        logic [7:0] eq;
        bit         ee;
        if (exp_q_fifo.size() == 0) begin
            check("scoreboard_empty", 32'(exp_q_fifo.size()), 32'd1);
            return;
        end
        eq = exp_q_fifo.pop_front();
        ee = exp_e_fifo.pop_front();
        for (int s = 0; s < stall; s++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_q", 32'(rsp_q), 32'(eq));
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
            check("stall_jk_j", 32'(jk_j), 32'd0);
            @(posedge clk1); #1;
        end
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_q", 32'(rsp_q), 32'(eq));
        check("rsp_err", 32'(rsp_err), 32'(ee));
        rsp_ready = 1'b1;
        @(posedge clk1); #1;
        rsp_ready = 1'b0;
        check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_hs_rsp_err", 32'(rsp_err), 32'd0);
        check("post_hs_jk_j", 32'(jk_j), 32'd0);
    endtask

    initial begin
        logic [1:0] rop;
        logic [7:0] rmask;
        logic [3:0] rcnt;

        s_reset   = 1'b1;
        bank_rst  = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_mask  = 8'h00;
        cmd_count = 4'd0;
        rsp_ready = 1'b0;
        stuck     = 8'h00;
        q_track   = 8'h00;

        // Reset values
        repeat (2) @(posedge clk1);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_jk_j", 32'(jk_j), 32'd0);
        check("rst_jk_k", 32'(jk_k), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_q", 32'(rsp_q), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        s_reset  = 1'b0;
        bank_rst = 1'b0;
        @(posedge clk1); #1;
        check("rst_bank_q", 32'(jk_q), 32'h00);

        // Set with count 0 (one pulse), then 3-pulse toggle
        issue(2'b01, 8'h0F, 4'd0, 1'b1);
        watch(2'b01, 8'h0F, 4'd0);
        respond(0);
        issue(2'b11, 8'hFF, 4'd3, 1'b1);
        watch(2'b11, 8'hFF, 4'd3);
        respond(0);
        check("bank_after_toggle", 32'(jk_q), 32'hF0);

        // Clear, timed hold, then a few random commands
        issue(2'b10, 8'hC0, 4'd1, 1'b1);
        watch(2'b10, 8'hC0, 4'd1);
        respond(0);
        issue(2'b00, 8'hFF, 4'd2, 1'b1);
        watch(2'b00, 8'hFF, 4'd2);
        respond(1);
        for (int r = 0; r < 6; r++) begin
            rop   = 2'($urandom);
            rmask = 8'($urandom);
            rcnt  = 4'($urandom_range(0, 4));
            issue(rop, rmask, rcnt, 1'b1);
            watch(rop, rmask, rcnt);
            respond(int'($urandom_range(0, 2)));
        end

        // Backpressure with cmd_valid held high through the stall
        bank_reset();
        issue(2'b01, 8'h30, 4'd2, 1'b1);
        watch(2'b01, 8'h30, 4'd2);
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_mask  = 8'h10;
        cmd_count = 4'd1;
        respond(5);
        check("bp_not_accepted_busy", 32'(busy), 32'd0);
        issue(2'b10, 8'h10, 4'd1, 1'b1);
        watch(2'b10, 8'h10, 4'd1);
        respond(0);
        check("bp_bank_q", 32'(jk_q), 32'h20);

        // Reset during SETTLE of a 5-pulse toggle
        bank_reset();
        issue(2'b11, 8'hFF, 4'd5, 1'b0);
        check("r5_drive_jk_j", 32'(jk_j), 32'hFF);
        @(posedge clk1); #1;
        check("r5_settle_jk_j", 32'(jk_j), 32'h00);
        check("r5_settle_busy", 32'(busy), 32'd1);
        #2 s_reset = 1'b1;
        #1;
        check("r5_cmd_ready", 32'(cmd_ready), 32'd1);
        check("r5_busy", 32'(busy), 32'd0);
        check("r5_jk_j", 32'(jk_j), 32'd0);
        check("r5_jk_k", 32'(jk_k), 32'd0);
        @(posedge clk1); #1;
        s_reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk1); #1;
            check("r5_no_rsp", 32'(rsp_valid), 32'd0);
            check("r5_jk_quiet", 32'({jk_j, jk_k}), 32'd0);
        end
        check("r5_bank_hold", 32'(jk_q), 32'hFF);

        // Stuck-at-0 on bit 3: read-back mismatch flagged only with the verify feature
        bank_reset();
        stuck = 8'h08;
        issue(2'b01, 8'h08, 4'd1, 1'b1);
        watch(2'b01, 8'h08, 4'd1);
        respond(0);
        stuck = 8'h00;

        check("scoreboard_drained", 32'(exp_q_fifo.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
